// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan controller.
// Holds the digit count, field widths, default prescale and the next-enabled search.
package seg_scan_pkg;

  localparam int NUM_DIGITS  = 8;
  localparam int SEL_W       = 3;
  localparam int NIB_W       = 4;
  localparam int DIV_DEFAULT = 100000;

  // Return the first enabled index after cur, searching cur+1 .. cur+NUM_DIGITS
  // modulo NUM_DIGITS. The last candidate is cur itself, so a lone enabled
  // current digit is kept. With no bit set the current index is held.
  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0]      cur,
                                                input logic [NUM_DIGITS-1:0] mask);
    logic [SEL_W-1:0] res;
    logic [SEL_W-1:0] idx;
    logic             found;
    res   = cur;
    found = 1'b0;
    for (int k = 1; k <= NUM_DIGITS; k++) begin
      idx = cur + SEL_W'(k);
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_tick_gen.sv
// Slot prescaler: counts 0..DIV-1 and flags the last cycle of every slot.
// tick is a decode of the registered count, so it is glitch-free and lasts one cycle.
// Free-running; nothing but reset disturbs the count.
module tick_gen
  import seg_scan_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int             CW   = $clog2(DIV);
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Slot counter, wraps to zero after the last cycle of the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan controller: 8-digit nibble register file, time-multiplexed onto one decoder.
// sel advances on the edge where tick is high; digit_out/blank follow registered sel.
// No handshake: writes are accepted every cycle, mask changes act on the next advance.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [SEL_W-1:0]      wr_addr,
  input  logic [NIB_W-1:0]      wr_data,
  input  logic [NUM_DIGITS-1:0] en_mask,
  output logic [NIB_W-1:0]      digit_out,
  output logic [SEL_W-1:0]      sel,
  output logic                  blank,
  output logic                  tick
);

  logic [NIB_W-1:0] regs [NUM_DIGITS];

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Digit register file; a write lands on the same edge as any sel advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Advance to the next enabled digit at each slot boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= '0;
    end else if (tick) begin
      sel <= next_sel(sel, en_mask);
    end
  end

  // Read port and blanking are straight decodes of registered sel; the decoder
  // wires hang directly off sel and digit_out.
  assign digit_out = regs[sel];
  assign blank     = ~en_mask[sel];

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIV=4: a slot-level model is checked on
// every falling edge, and literal expectations pin the model at key points.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [7:0] en_mask;
  logic [3:0] digit_out;
  logic [2:0] sel;
  logic       blank;
  logic       tick;

  int vecs = 0;
  int errs = 0;

  seg_scan_ctrl #(.DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .en_mask   (en_mask),
    .digit_out (digit_out),
    .sel       (sel),
    .blank     (blank),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Time within a slot is an integer 0..3; the displayed digit hops to the
  // next enabled position in circular order when a slot ends.
  int m_regs [8];
  int m_sel;
  int m_phase;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 0;
      m_sel   = 0;
      m_phase = 0;
    end else begin
      if (m_phase == 3) begin
        for (int k = 1; k <= 8; k++) begin
          if (en_mask[(m_sel + k) % 8]) begin
            m_sel = (m_sel + k) % 8;
            break;
          end
        end
      end
      if (wr_en) m_regs[wr_addr] = int'(wr_data);
      m_phase = (m_phase + 1) % 4;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("model_sel",   int'(sel),       m_sel);
    chk("model_digit", int'(digit_out), m_regs[m_sel]);
    chk("model_blank", int'(blank),     en_mask[m_sel] ? 0 : 1);
    chk("model_tick",  int'(tick),      (rst_n && m_phase == 3) ? 1 : 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Run until the edge that advances sel has just passed.
  task automatic wait_tick();
    bit seen;
    seen = tick;
    for (int i = 0; i < 12 && !seen; i++) begin
      step(1);
      seen = tick;
    end
    if (!seen) chk("tick_timeout", 0, 1);
    step(1);
  endtask

  task automatic write(input int addr, input int data);
    wr_en   = 1'b1;
    wr_addr = 3'(addr);
    wr_data = 4'(data);
    step(1);
    wr_en   = 1'b0;
  endtask

  task automatic do_reset(input logic [7:0] mask);
    rst_n   = 1'b0;
    en_mask = mask;
    step(2);
    rst_n   = 1'b1;
  endtask

  int exp_walk [6] = '{2, 5, 7, 2, 5, 7};

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    en_mask = 8'hFE;
    step(1);
    // reset state
    chk("rst_sel",   int'(sel),       0);
    chk("rst_digit", int'(digit_out), 0);
    chk("rst_tick",  int'(tick),      0);
    chk("rst_blank_masked", int'(blank), 1);
    en_mask = 8'hFF;
    #1;
    chk("rst_blank_enabled", int'(blank), 0);
    step(1);
    rst_n = 1'b1;

    // plain scan: tick on the DIV-th edge after release
    step(2);
    chk("scan_no_tick_early", int'(tick), 0);
    step(1);
    chk("scan_first_tick", int'(tick), 1);
    chk("scan_sel_before", int'(sel),  0);
    step(1);
    chk("scan_sel_1", int'(sel), 1);
    for (int k = 2; k <= 8; k++) begin
      wait_tick();
      chk("scan_walk", int'(sel), k % 8);
      chk("scan_digit0", int'(digit_out), 0);
    end

    // register file contents shown in scan order
    do_reset(8'hFF);
    for (int i = 0; i < 8; i++) write(i, i + 8);
    chk("wr_sel_after", int'(sel), 2);
    for (int k = 1; k <= 8; k++) begin
      wait_tick();
      chk("wr_scan_sel",   int'(sel),       (2 + k) % 8);
      chk("wr_scan_digit", int'(digit_out), ((2 + k) % 8) + 8);
    end

    // sparse mask skips disabled digits
    do_reset(8'b1010_0100);
    chk("sparse_blank0", int'(blank), 1);
    chk("sparse_sel0",   int'(sel),   0);
    for (int k = 0; k < 6; k++) begin
      wait_tick();
      chk("sparse_sel",   int'(sel),   exp_walk[k]);
      chk("sparse_blank", int'(blank), 0);
    end

    // empty mask freezes sel; single bit jumps to it
    en_mask = 8'h00;
    #1;
    chk("empty_blank_now", int'(blank), 1);
    wait_tick();
    wait_tick();
    chk("empty_sel_held", int'(sel),   7);
    chk("empty_blank",    int'(blank), 1);
    en_mask = 8'h08;
    wait_tick();
    chk("single_sel3", int'(sel), 3);
    wait_tick();
    chk("single_sel3_stays", int'(sel), 3);

    // write coinciding with tick
    do_reset(8'hFF);
    step(3);
    chk("coinc_tick", int'(tick), 1);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'hC;
    step(1);
    wr_en = 1'b0;
    chk("coinc_old_sel_sel",   int'(sel),       1);
    chk("coinc_old_sel_digit", int'(digit_out), 0);
    step(3);
    chk("coinc_tick2", int'(tick), 1);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'hC;
    step(1);
    wr_en = 1'b0;
    chk("coinc_new_sel_sel",   int'(sel),       2);
    chk("coinc_new_sel_digit", int'(digit_out), 12);
    // masking the displayed digit mid-slot
    en_mask = 8'hFB;
    #1;
    chk("midslot_blank", int'(blank), 1);
    chk("midslot_sel",   int'(sel),   2);
    step(1);
    chk("midslot_sel_held", int'(sel), 2);
    en_mask = 8'hFF;

    // reset in the middle of a slot
    do_reset(8'hFF);
    write(5, 7);
    step(21);
    chk("midrst_pre_sel",   int'(sel),       5);
    chk("midrst_pre_digit", int'(digit_out), 7);
    rst_n = 1'b0;
    #1;
    chk("midrst_sel",   int'(sel),       0);
    chk("midrst_digit", int'(digit_out), 0);
    chk("midrst_tick",  int'(tick),      0);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'h9;
    step(2);
    wr_en = 1'b0;
    rst_n = 1'b1;
    step(3);
    chk("midrst_tick_after", int'(tick),      1);
    chk("midrst_wr_ignored", int'(digit_out), 0);
    step(1);
    chk("midrst_sel1", int'(sel), 1);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
